// File: rtl/debounce_scan_ctrl_if.sv
// Event handshake bundle between the debounce controller (master) and the
// CSR/interrupt consumer (slave).
interface debounce_scan_ctrl_if #(
    parameter int unsigned NumCh = 4
) ();
    localparam int unsigned CW = $clog2(NumCh);

    logic          evt_valid_o;
    logic          evt_ready_i;
    logic [CW-1:0] evt_ch_o;
    logic          evt_level_o;

    modport master (
        output evt_valid_o,
        output evt_ch_o,
        output evt_level_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_ch_o,
        input  evt_level_o,
        output evt_ready_i
    );
endinterface

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed switch debouncer: one shared engine scans all channels per
// 1 ms tick, queues level flips per channel and drains them round-robin.
module debounce_scan_ctrl #(
    parameter int unsigned ClkFreq    = 100_000_000,
    parameter int unsigned StableTime = 10,
    parameter int unsigned NumCh      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumCh-1:0]          sw_i,
    output logic [NumCh-1:0]          db_level_o,
    output logic [NumCh-1:0]          db_tick_o,
    debounce_scan_ctrl_if.master      evt,
    output logic                      ovf_o,
    input  logic                      ovf_clr_i,
    output logic                      scan_busy_o
);
    localparam int unsigned TickDiv = ClkFreq / 1000;
    localparam int unsigned PW      = $clog2(TickDiv);
    localparam int unsigned CW      = $clog2(NumCh);
    localparam int unsigned NW      = $clog2(StableTime + 1);

    if (TickDiv < NumCh + 2) begin : g_tickdiv_chk
        $fatal(1, "debounce_scan_ctrl: TickDiv must be >= NumCh+2");
    end
    if (StableTime < 1 || StableTime > 255) begin : g_stable_chk
        $fatal(1, "debounce_scan_ctrl: StableTime out of range 1..255");
    end
    if (NumCh < 2 || NumCh > 16) begin : g_numch_chk
        $fatal(1, "debounce_scan_ctrl: NumCh out of range 2..16");
    end

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t          r_state;
    logic [NumCh-1:0] r_sync1, r_sync2;
    logic [PW-1:0]   r_presc;
    logic [CW-1:0]   r_idx;
    logic [NumCh-1:0] r_level, r_tick, r_pend, r_plev;
    logic [NW-1:0]   r_cnt [NumCh];
    logic [CW-1:0]   r_ptr;
    logic            r_evt_valid;
    logic [CW-1:0]   r_evt_ch;
    logic            r_evt_level;
    logic            r_ovf;

    logic            w_tick, w_visit, w_samp, w_cur, w_flip;
    logic [NW-1:0]   w_cnt;
    logic            w_load, w_found, w_ovf_set;
    logic [CW-1:0]   w_gnt_ch;
    logic [NumCh-1:0] w_pend_nxt, w_tick_nxt;

    // Shared compare engine: operands of the channel being visited
    assign w_tick  = (r_presc == PW'(TickDiv - 1));
    assign w_visit = (r_state == S_SCAN);
    assign w_samp  = r_sync2[r_idx];
    assign w_cur   = r_level[r_idx];
    assign w_cnt   = r_cnt[r_idx];
    assign w_flip  = w_visit && (w_samp != w_cur) && ((32'(w_cnt) + 32'd1) == StableTime);
    assign w_load  = (!r_evt_valid || evt.evt_ready_i) && (|r_pend);

    // First pending channel after the round-robin pointer, wrapping
    always_comb begin
        logic [CW-1:0] c;
        c        = '0;
        w_found  = 1'b0;
        w_gnt_ch = '0;
        for (int unsigned k = 1; k <= NumCh; k++) begin
            c = CW'((32'(r_ptr) + k) % NumCh);
            if (!w_found && r_pend[c]) begin
                w_found  = 1'b1;
                w_gnt_ch = c;
            end
        end
    end

    // A flip onto a still-pending channel overwrites it unless that channel is being granted now
    always_comb begin
        w_pend_nxt = r_pend;
        w_tick_nxt = '0;
        w_ovf_set  = 1'b0;
        if (w_load) w_pend_nxt[w_gnt_ch] = 1'b0;
        if (w_flip) begin
            w_ovf_set         = r_pend[r_idx] && !(w_load && (w_gnt_ch == r_idx));
            w_pend_nxt[r_idx] = 1'b1;
            w_tick_nxt[r_idx] = w_samp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_presc     <= '0;
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_level     <= '0;
            r_tick      <= '0;
            r_pend      <= '0;
            r_plev      <= '0;
            for (int i = 0; i < int'(NumCh); i++) r_cnt[i] <= '0;
            r_ptr       <= CW'(NumCh - 1);
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_level <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                    end
                end
                S_SCAN: begin
                    if (r_idx == CW'(NumCh - 1)) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_visit) begin
                if (w_samp == w_cur) begin
                    r_cnt[r_idx] <= '0;
                end else if (w_flip) begin
                    r_cnt[r_idx]   <= '0;
                    r_level[r_idx] <= w_samp;
                    r_plev[r_idx]  <= w_samp;
                end else begin
                    r_cnt[r_idx] <= w_cnt + NW'(1);
                end
            end

            r_tick <= w_tick_nxt;
            r_pend <= w_pend_nxt;

            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_gnt_ch;
                r_evt_level <= r_plev[w_gnt_ch];
                r_ptr       <= w_gnt_ch;
            end else if (evt.evt_ready_i) begin
                r_evt_valid <= 1'b0;
            end

            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (ovf_clr_i) r_ovf <= 1'b0;
        end
    end

    assign db_level_o      = r_level;
    assign db_tick_o       = r_tick;
    assign ovf_o           = r_ovf;
    assign scan_busy_o     = (r_state == S_SCAN);
    assign evt.evt_valid_o = r_evt_valid;
    assign evt.evt_ch_o    = r_evt_ch;
    assign evt.evt_level_o = r_evt_level;
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Randomized + directed bench for debounce_scan_ctrl against a behavioural model.
`timescale 1ns/1ps
module tb_debounce_scan_ctrl;
    localparam int unsigned NCH   = 4;
    localparam int unsigned STAB  = 3;
    localparam int          TDIV  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] sw = '0;
    logic           ready = 1'b0;
    logic           ovf_clr = 1'b0;
    logic [NCH-1:0] db_level, db_tick;
    logic           ovf, busy;

    int n_chk = 0;
    int n_err = 0;

    debounce_scan_ctrl_if #(.NumCh(NCH)) evt_if ();
    assign evt_if.evt_ready_i = ready;

    debounce_scan_ctrl #(.ClkFreq(8000), .StableTime(STAB), .NumCh(NCH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sw_i        (sw),
        .db_level_o  (db_level),
        .db_tick_o   (db_tick),
        .evt         (evt_if),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .scan_busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: time since reset decides which channel is sampled;
    // pending events live in per-channel slots drained round-robin.
    int             m_t;
    logic [NCH-1:0] m_d1, m_d2, m_level, m_pend, m_plev;
    int             m_run [NCH];
    int             m_last;
    logic           e_valid, e_level, e_ovf;
    int             e_ch;
    logic [NCH-1:0] e_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_d1 = '0; m_d2 = '0; m_level = '0; m_pend = '0; m_plev = '0;
            for (int i = 0; i < int'(NCH); i++) m_run[i] = 0;
            m_last = NCH - 1;
            e_valid = 0; e_ch = 0; e_level = 0; e_ovf = 0; e_tick = '0;
        end else begin
            int  e, ch, c;
            bit  found, oset;
            logic s;
            e = m_t + 1;
            e_tick = '0;
            oset = 0;
            if (!e_valid || ready) begin
                e_valid = 0;
                found = 0;
                for (int k = 1; k <= int'(NCH); k++) begin
                    c = (m_last + k) % NCH;
                    if (!found && m_pend[c]) begin
                        found = 1; e_valid = 1; e_ch = c; e_level = m_plev[c];
                        m_pend[c] = 0; m_last = c;
                    end
                end
            end
            if (e > TDIV && ((e - 1) % TDIV) < int'(NCH)) begin
                ch = (e - 1) % TDIV;
                s  = m_d2[ch];
                if (s != m_level[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == int'(STAB)) begin
                        m_level[ch] = s;
                        m_run[ch] = 0;
                        e_tick[ch] = s;
                        if (m_pend[ch]) oset = 1;
                        m_pend[ch] = 1;
                        m_plev[ch] = s;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            if (oset) e_ovf = 1;
            else if (ovf_clr) e_ovf = 0;
            m_d2 = m_d1;
            m_d1 = sw;
            m_t = e;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", int'(db_level), int'(m_level));
            chk("tick", int'(db_tick), int'(e_tick));
            chk("busy", int'(busy), int'(m_t >= TDIV && (m_t % TDIV) < int'(NCH)));
            chk("valid", int'(evt_if.evt_valid_o), int'(e_valid));
            chk("ovf", int'(ovf), int'(e_ovf));
            if (e_valid) begin
                chk("evt_ch", int'(evt_if.evt_ch_o), e_ch);
                chk("evt_level", int'(evt_if.evt_level_o), int'(e_level));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; sw = '0; ready = 0; ovf_clr = 0;
        repeat (3) @(negedge clk);
        chk("rst_level", int'(db_level), 0);
        chk("rst_valid", int'(evt_if.evt_valid_o), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1;
    endtask

    initial begin
        #300_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, vcnt, lcnt;
        bit found;

        // Idle after reset
        do_reset();
        busy_cnt = 0; vcnt = 0; lcnt = 0;
        repeat (100) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            vcnt += int'(evt_if.evt_valid_o);
            lcnt += int'(db_level != '0);
        end
        chk("idle_busy_cycles", busy_cnt, 48);
        chk("idle_events", vcnt, 0);
        chk("idle_levels", lcnt, 0);

        // Clean press on ch2
        do_reset();
        ready = 1;
        repeat (5) @(negedge clk);
        sw[2] = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (db_level[2]) found = 1;
        end
        chk("press_found", int'(found), 1);
        chk("press_tick", int'(db_tick), 4);
        @(negedge clk);
        chk("press_evt_valid", int'(evt_if.evt_valid_o), 1);
        chk("press_evt_ch", int'(evt_if.evt_ch_o), 2);
        chk("press_evt_level", int'(evt_if.evt_level_o), 1);
        repeat (10) @(negedge clk);

        // Bounce on ch1, then settle high
        do_reset();
        ready = 1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            sw[1] = ~sw[1];
            repeat (5) @(negedge clk);
        end
        sw[1] = 1;
        repeat (48) @(negedge clk);
        chk("bounce_level", int'(db_level[1]), 1);

        // Arbitration ch0, ch1, ch3 with consumer stalled
        do_reset();
        repeat (2) @(negedge clk);
        sw = 4'b1011;
        repeat (40) @(negedge clk);
        chk("arb_hold_ch_a", int'(evt_if.evt_ch_o), 0);
        repeat (8) @(negedge clk);
        chk("arb_hold_valid", int'(evt_if.evt_valid_o), 1);
        chk("arb_hold_ch_b", int'(evt_if.evt_ch_o), 0);
        ready = 1;
        @(negedge clk);
        chk("arb_second", int'(evt_if.evt_ch_o), 1);
        @(negedge clk);
        chk("arb_third", int'(evt_if.evt_ch_o), 3);
        @(negedge clk);
        chk("arb_drained", int'(evt_if.evt_valid_o), 0);

        // Overflow: ch3 occupies the output, ch0 flips twice while stalled
        do_reset();
        sw[3] = 1;
        repeat (48) @(negedge clk);
        sw[0] = 1;
        repeat (48) @(negedge clk);
        sw[0] = 0;
        repeat (48) @(negedge clk);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_head_ch", int'(evt_if.evt_ch_o), 3);
        ready = 1;
        @(negedge clk);
        chk("ovf_evt_ch", int'(evt_if.evt_ch_o), 0);
        chk("ovf_evt_level", int'(evt_if.evt_level_o), 0);
        @(negedge clk);
        chk("ovf_drained", int'(evt_if.evt_valid_o), 0);
        ovf_clr = 1;
        @(negedge clk);
        ovf_clr = 0;
        chk("ovf_cleared", int'(ovf), 0);

        // Async reset mid-scan with an event outstanding
        do_reset();
        sw = 4'b0011;
        repeat (48) @(negedge clk);
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge clk);
            #2;
            if (busy) found = 1;
        end
        chk("areset_busy_seen", int'(found), 1);
        chk("areset_pre_valid", int'(evt_if.evt_valid_o), 1);
        rst_n = 0;
        #1;
        chk("areset_level", int'(db_level), 0);
        chk("areset_valid", int'(evt_if.evt_valid_o), 0);
        chk("areset_busy", int'(busy), 0);
        @(negedge clk);
        sw = '0; ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            vcnt += int'(evt_if.evt_valid_o);
        end
        chk("areset_no_stale", vcnt, 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) sw[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) ready = ~ready;
            ovf_clr = ($urandom_range(0, 59) == 0);
        end
        ovf_clr = 0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
